// File: rtl/if_stage_fetch.sv
// Instruction fetch: owns the PC, one outstanding imem req/gnt/rvalid fetch, registered IF/ID outputs.
// Latency gnt->valid 2 cycles; freeze holds outputs and PC, parking a late response in a hold buffer.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        valid
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] hold_buf;
    logic        kill;

    assign pc_next   = pc + PC_INC;
    assign imem_req  = rst && (state == REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= REQ;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            hold_buf    <= '0;
            pc_out      <= '0;
            instruction <= '0;
            valid       <= 1'b0;
        end else if (br_taken) begin
            valid       <= 1'b0;
            instruction <= '0;
            pc          <= br_addr;
            case (state)
                // A granted-but-unreturned fetch belongs to the old path: drop its response.
                REQ: begin
                    if (imem_gnt) begin
                        kill  <= 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill  <= 1'b0;
                        state <= REQ;
                    end else begin
                        kill <= 1'b1;
                    end
                end
                HOLD:    state <= REQ;
                default: state <= REQ;
            endcase
        end else begin
            if (!freeze)
                valid <= 1'b0;
            case (state)
                REQ: begin
                    if (imem_gnt)
                        state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else if (!valid || !freeze) begin
                            instruction <= imem_rdata;
                            pc_out      <= pc_next;
                            valid       <= 1'b1;
                            pc          <= pc_next;
                            state       <= REQ;
                        end else begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        instruction <= hold_buf;
                        pc_out      <= pc_next;
                        valid       <= 1'b1;
                        pc          <= pc_next;
                        state       <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule
